// File: rtl/ctrl_defs.sv
// ctrl_defs: shared definitions for the multicycle ARM control unit.
//   - state_t     : 4-bit FSM state encoding
//   - ALU_*       : ALUControl codes
//   - IMM_*       : ImmSrc codes
//   - RES_*       : ResultSrc codes
//   - SRCB_*      : ALUSrcB codes
//   - COND_*      : condition field codes (EQ..AL)
//   - CMD_*       : data-processing cmd field codes
package ctrl_defs;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control unit <-> datapath/memory signal bundle.
//   master : the control unit (consumes Instr/ALUFlags, drives selects/enables)
//   slave  : the datapath side (drives Instr/ALUFlags, consumes selects/enables)
interface multicycle_ctrl_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, IRWrite, MemWrite;
    logic        AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
    logic [3:0]  rot;
    logic        DivMulSrc, shift_op, div_op, mla_op, div_sel;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA,
               RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, rot,
               DivMulSrc, shift_op, div_op, mla_op, div_sel
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, RegWrite, IRWrite, MemWrite, AdrSrc, ALUSrcA,
               RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl, rot,
               DivMulSrc, shift_op, div_op, mla_op, div_sel
    );
endinterface

// File: rtl/multicycle_ctrl_cond_check.sv
// cond_check: combinational ARM condition evaluation.
//   cond_i  : Instr[31:28]
//   flags_i : {N,Z,C,V}
//   pass_o  : 1 when the condition holds (1111 is treated as never)
module cond_check
    import ctrl_defs::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = ~z & (n == v);
            COND_LE: pass_o = z | (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle ARM core.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : master side of multicycle_ctrl_if (Instr/ALUFlags in,
//                all datapath selects, write enables and extension selects out)
// Holds the FSM, instruction decoder, NZCV flag register and cond_ex register.
module multicycle_ctrl
    import ctrl_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    state_t      state_q, state_d, out_st;
    logic [3:0]  flags_q, flags_d;
    logic        cond_ex_q, cond_ex_d;
    logic        cond_pass;

    logic [1:0]  op;
    logic [3:0]  cmd, rd;
    logic        imm_bit, s_bit, l_bit;
    logic        is_mul, is_div, is_dp, is_cmp, is_mov, cmd_ok, arith;
    logic [1:0]  alu_ctl;
    logic        unused_instr;

    assign op      = bus.Instr[27:26];
    assign imm_bit = bus.Instr[25];
    assign cmd     = bus.Instr[24:21];
    assign s_bit   = bus.Instr[20];
    assign l_bit   = bus.Instr[20];
    assign unused_instr = ^bus.Instr[3:0];

    // Divide lives in the Op=01 space, so it must win over the memory decode.
    assign is_div = (bus.Instr[27:23] == 5'b01110) && !bus.Instr[22] &&
                    bus.Instr[20] && (bus.Instr[7:4] == 4'b0001);
    assign is_mul = (op == 2'b00) && !imm_bit && (bus.Instr[7:4] == 4'b1001);
    assign is_dp  = (op == 2'b00) && !is_mul && cmd_ok;
    assign is_cmp = is_dp && (cmd == CMD_CMP);
    assign is_mov = is_dp && (cmd == CMD_MOV);

    // MUL/MLA/SDIV/UDIV encode the destination in [19:16]; [15:12] is Ra there.
    assign rd = (is_mul || is_div) ? bus.Instr[19:16] : bus.Instr[15:12];

    always_comb begin
        cmd_ok  = 1'b1;
        arith   = 1'b0;
        alu_ctl = ALU_ADD;
        case (cmd)
            CMD_ADD: begin alu_ctl = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin alu_ctl = ALU_SUB; arith = 1'b1; end
            CMD_CMP: begin alu_ctl = ALU_SUB; arith = 1'b1; end
            CMD_AND: alu_ctl = ALU_AND;
            CMD_ORR: alu_ctl = ALU_ORR;
            CMD_MOV: alu_ctl = ALU_ADD;
            default: cmd_ok  = 1'b0;
        endcase
        if (is_mul || is_div) alu_ctl = ALU_ADD;
    end

    cond_check u_cond_check (
        .cond_i  (bus.Instr[31:28]),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // While reset is high the outputs present FETCH with write enables masked.
    assign out_st = reset ? FETCH : state_q;

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;

        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.RegSrc     = '0;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ImmSrc     = IMM_8;
        bus.ALUControl = ALU_ADD;
        bus.rot        = bus.Instr[11:8];
        bus.DivMulSrc  = 1'b0;
        bus.shift_op   = 1'b0;
        bus.div_op     = 1'b0;
        bus.mla_op     = 1'b0;
        bus.div_sel    = 1'b0;

        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                cond_ex_d = cond_pass;
                if (!cond_pass)          state_d = FETCH;
                else if (is_div)         state_d = EXECR;
                else if (op == 2'b01)    state_d = MEMADR;
                else if (op == 2'b10)    state_d = BRANCH;
                else if (is_mul)         state_d = EXECR;
                else if (is_dp)          state_d = imm_bit ? EXECI : EXECR;
                else                     state_d = FETCH;
            end
            MEMADR: state_d = l_bit ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            EXECR, EXECI: begin
                state_d = ALUWB;
                if (s_bit && cond_ex_q && is_dp) begin
                    flags_d[3:2] = bus.ALUFlags[3:2];
                    if (arith) flags_d[1:0] = bus.ALUFlags[1:0];
                end
            end
            default: state_d = FETCH;
        endcase

        case (out_st)
            FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            MEMADR: begin
                bus.ALUSrcB = SRCB_EXT;
                bus.ImmSrc  = IMM_12;
            end
            MEMRD:  bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = RES_DATA;
                if (rd == 4'hF) bus.PCWrite = 1'b1;
                else            bus.RegWrite = 1'b1;
            end
            MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                bus.RegSrc   = 2'b10;
            end
            EXECR: bus.ALUControl = alu_ctl;
            EXECI: begin
                bus.ALUSrcB    = SRCB_EXT;
                bus.ALUControl = alu_ctl;
            end
            ALUWB: begin
                if (!is_cmp) begin
                    if (rd == 4'hF) bus.PCWrite = 1'b1;
                    else            bus.RegWrite = 1'b1;
                end
            end
            BRANCH: begin
                bus.RegSrc    = 2'b01;
                bus.ALUSrcB   = SRCB_EXT;
                bus.ImmSrc    = IMM_24;
                bus.ResultSrc = RES_ALURESULT;
                bus.PCWrite   = 1'b1;
            end
            default: ;
        endcase

        if (out_st == EXECR || out_st == EXECI || out_st == ALUWB) begin
            bus.DivMulSrc = is_mul | is_div;
            bus.shift_op  = is_mov;
            bus.div_op    = is_div;
            bus.mla_op    = is_mul & bus.Instr[21];
            bus.div_sel   = is_div & ~bus.Instr[21];
        end

        if (reset) begin
            bus.PCWrite  = 1'b0;
            bus.RegWrite = 1'b0;
            bus.IRWrite  = 1'b0;
            bus.MemWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed + randomized check of multicycle_ctrl against an
// instruction-level model that predicts the per-cycle control trace and NZCV.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pcw, rgw, irw, mw, adr, srca;
        logic [1:0] regsrc, srcb, res, imm, aluc;
        logic [3:0] rot;
        logic       dms, sh, dv, mla, dsel;
    } vec_t;

    localparam int K_DP = 0, K_MUL = 1, K_DIV = 2, K_MEM = 3, K_BR = 4, K_BAD = 5;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [3:0]  fl = '0;   // model NZCV

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic vec_t observe();
        vec_t v;
        v.pcw = bus.PCWrite;  v.rgw = bus.RegWrite; v.irw = bus.IRWrite;
        v.mw = bus.MemWrite;  v.adr = bus.AdrSrc;   v.srca = bus.ALUSrcA;
        v.regsrc = bus.RegSrc; v.srcb = bus.ALUSrcB; v.res = bus.ResultSrc;
        v.imm = bus.ImmSrc;   v.aluc = bus.ALUControl; v.rot = bus.rot;
        v.dms = bus.DivMulSrc; v.sh = bus.shift_op; v.dv = bus.div_op;
        v.mla = bus.mla_op;   v.dsel = bus.div_sel;
        return v;
    endfunction

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0: return z;          4'd1: return !z;
            4'd2: return cy;         4'd3: return !cy;
            4'd4: return n;          4'd5: return !n;
            4'd6: return v;          4'd7: return !v;
            4'd8: return cy && !z;   4'd9: return !cy || z;
            4'd10: return n == v;    4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int classify(input logic [31:0] ins);
        logic [3:0] c;
        c = ins[24:21];
        if (ins[27:23] == 5'b01110 && !ins[22] && ins[20] && ins[7:4] == 4'b0001) return K_DIV;
        if (ins[27:26] == 2'b01) return K_MEM;
        if (ins[27:26] == 2'b10) return K_BR;
        if (ins[27:26] == 2'b11) return K_BAD;
        if (!ins[25] && ins[7:4] == 4'b1001) return K_MUL;
        if (c == 4'b0100 || c == 4'b0010 || c == 4'b1010 || c == 4'b0000 ||
            c == 4'b1100 || c == 4'b1101) return K_DP;
        return K_BAD;
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] c);
        case (c)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic vec_t fetch_vec(input logic [31:0] ins);
        vec_t v = '0;
        v.rot = ins[11:8];
        v.pcw = 1'b1; v.irw = 1'b1; v.srca = 1'b1; v.srcb = 2'b10; v.res = 2'b10;
        return v;
    endfunction

    task automatic run_instr(input string name, input logic [31:0] ins,
                             input logic [3:0] af, input int rst_at);
        vec_t q[$];
        vec_t v, base, ext;
        int   kind;
        logic pass, hit_rst;
        logic [3:0] rdn;

        kind    = classify(ins);
        pass    = cond_ok(ins[31:28], fl);
        hit_rst = 1'b0;
        base    = '0;
        base.rot = ins[11:8];

        q.push_back(fetch_vec(ins));
        v = base; v.srca = 1'b1; v.srcb = 2'b10; v.res = 2'b10;
        q.push_back(v);

        if (pass && kind == K_MEM) begin
            v = base; v.srcb = 2'b01; v.imm = 2'b01;
            q.push_back(v);
            if (ins[20]) begin
                v = base; v.adr = 1'b1;
                q.push_back(v);
                v = base; v.res = 2'b01;
                if (ins[15:12] == 4'hF) v.pcw = 1'b1; else v.rgw = 1'b1;
                q.push_back(v);
            end else begin
                v = base; v.adr = 1'b1; v.mw = 1'b1; v.regsrc = 2'b10;
                q.push_back(v);
            end
        end else if (pass && kind == K_BR) begin
            v = base; v.regsrc = 2'b01; v.srcb = 2'b01; v.imm = 2'b10;
            v.res = 2'b10; v.pcw = 1'b1;
            q.push_back(v);
        end else if (pass && (kind == K_DP || kind == K_MUL || kind == K_DIV)) begin
            ext = base;
            ext.dms  = (kind == K_MUL || kind == K_DIV);
            ext.sh   = (kind == K_DP && ins[24:21] == 4'b1101);
            ext.dv   = (kind == K_DIV);
            ext.mla  = (kind == K_MUL && ins[21]);
            ext.dsel = (kind == K_DIV && !ins[21]);
            v = ext;
            v.srcb = (kind == K_DP && ins[25]) ? 2'b01 : 2'b00;
            v.aluc = (kind == K_DP) ? alu_of(ins[24:21]) : 2'b00;
            q.push_back(v);
            v = ext;
            rdn = (kind == K_DP) ? ins[15:12] : ins[19:16];
            if (!(kind == K_DP && ins[24:21] == 4'b1010)) begin
                if (rdn == 4'hF) v.pcw = 1'b1; else v.rgw = 1'b1;
            end
            q.push_back(v);
        end

        for (int k = 0; k < q.size(); k++) begin
            bus.Instr    = ins;
            bus.ALUFlags = af;
            reset        = (k == rst_at);
            @(negedge clk);
            if (k == rst_at) begin
                v = fetch_vec(ins); v.pcw = 1'b0; v.irw = 1'b0;
                check($sformatf("%s reset@c%0d ins=%h", name, k, ins), 32'(observe()), 32'(v));
            end else begin
                check($sformatf("%s c%0d ins=%h", name, k, ins), 32'(observe()), 32'(q[k]));
            end
            @(posedge clk); #1;
            if (k == rst_at) begin
                reset   = 1'b0;
                hit_rst = 1'b1;
                break;
            end
        end

        if (hit_rst) fl = '0;
        else if (pass && kind == K_DP && ins[20]) begin
            fl[3:2] = af[3:2];
            if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010 || ins[24:21] == 4'b1010)
                fl[1:0] = af[1:0];
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0]  cnd, c;
        logic [31:0] r;
        cnd = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        r   = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
                case ($urandom_range(0, 7))
                    0: c = 4'b0100; 1: c = 4'b0010; 2: c = 4'b1010; 3: c = 4'b0000;
                    4: c = 4'b1100; 5: c = 4'b1101; 6: c = 4'b0001; default: c = 4'b1111;
                endcase
                return {cnd, 2'b00, r[25], c, r[20:0]};
            end
            4: return {cnd, 6'b000000, r[21:8], 4'b1001, r[3:0]};
            5: return {cnd, 5'b01110, 1'b0, r[21], 1'b1, r[19:8], 4'b0001, r[3:0]};
            6, 7: return {cnd, 2'b01, r[25:0]};
            8: return {cnd, 2'b10, r[25:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset        = 1'b1;
        bus.Instr    = 32'hE2811005;
        bus.ALUFlags = '0;
        repeat (2) begin
            @(negedge clk);
            v = fetch_vec(32'hE2811005); v.pcw = 1'b0; v.irw = 1'b0;
            check("in-reset", 32'(observe()), 32'(v));
        end
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr("ADDI", 32'hE2811005, 4'b0000, -1);
        run_instr("LDR",  32'hE5912004, 4'b0000, -1);
        run_instr("STR",  32'hE5812004, 4'b0000, -1);
        run_instr("CMP",  32'hE3510000, 4'b0100, -1);
        run_instr("BEQ-t",32'h0A000002, 4'b0000, -1);
        run_instr("CMP",  32'hE3510000, 4'b0000, -1);
        run_instr("BEQ-n",32'h0A000002, 4'b0100, -1);
        run_instr("CMP",  32'hE3510000, 4'b0110, -1);
        run_instr("MULS", 32'hE0130291, 4'b1001, -1);
        run_instr("BEQ-t",32'h0A000002, 4'b0000, -1);
        run_instr("BCS-t",32'h2A000002, 4'b0000, -1);
        run_instr("MUL",  32'hE0030291, 4'b0000, -1);
        run_instr("MLA",  32'hE0234291, 4'b0000, -1);
        run_instr("SDIV", 32'hE713F110, 4'b0000, -1);
        run_instr("UDIV", 32'hE733F110, 4'b0000, -1);
        run_instr("ANDS", 32'hE0110002, 4'b1011, -1);
        run_instr("BMI-t",32'h4A000002, 4'b0000, -1);
        run_instr("BCS-t",32'h2A000002, 4'b0000, -1);
        run_instr("STR-rst", 32'hE5812004, 4'b0000, 3);
        run_instr("BEQ-n",32'h0A000002, 4'b0000, -1);
        run_instr("BNE-t",32'h1A000002, 4'b0000, -1);
        run_instr("UNSUP",32'hEC000000, 4'b0000, -1);

        for (int i = 0; i < 300; i++) begin
            run_instr("rand", rand_instr(), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
